// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the fetch stage.
//   word_t        32-bit machine word
//   fetch_state_t fetch FSM states
//   WBYTES        bytes per instruction word
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_t;
    localparam word_t WBYTES = 32'd4;
endpackage

// File: rtl/ifid_skid.sv
// ifid_skid: one-entry buffer holding a fetched word while IF/ID is stalled.
//   CLK, RST      clock, synchronous active-high reset
//   load          capture {instr_in, npc_in}; entry becomes valid
//   drain         entry consumed by IF/ID; entry becomes empty
//   clear         entry discarded (flush, redirect, halt)
//   skid_instr, skid_npc, skid_valid  stored entry
module ifid_skid
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  drain,
    input  logic  clear,
    input  word_t instr_in,
    input  word_t npc_in,
    output word_t skid_instr,
    output word_t skid_npc,
    output logic  skid_valid
);
    always_ff @(posedge CLK) begin
        if (RST) begin
            skid_instr <= '0;
            skid_npc   <= '0;
            skid_valid <= 1'b0;
        end else begin
            if (load) begin
                skid_instr <= instr_in;
                skid_npc   <= npc_in;
            end
            skid_valid <= load | (skid_valid & ~(drain | clear));
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, I-cache request issue and IF/ID register writer.
//   CLK, RST            clock, synchronous active-high reset
//   ihit, imemload      I-cache hit and returned word
//   imemREN, imemaddr   read request and address (combinational from state)
//   ifW, ifRST          IF/ID write enable and flush from the hazard unit
//   redir_en, redir_pc  resolved branch/jump redirect
//   halt                stop fetching until reset
//   ifid_instr, ifid_npc, ifid_valid  IF/ID pipeline register
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ifW,
    input  logic  ifRST,
    input  logic  redir_en,
    input  word_t redir_pc,
    input  logic  halt,
    output word_t ifid_instr,
    output word_t ifid_npc,
    output logic  ifid_valid
);
    fetch_state_t fstate;
    word_t pc, pend_pc, pc_next4, skid_instr, skid_npc;
    logic  skid_valid, miss, run_fetch, hit_take;

    assign pc_next4 = pc + WBYTES;
    assign imemaddr = pc;
    // No request while the skid is full, so a stalled word is never refetched.
    assign imemREN  = (fstate == RUN) ? ~skid_valid : (fstate == DRAIN);
    assign miss     = imemREN & ~ihit;
    // Normal fetch path: nothing of higher priority this cycle.
    assign run_fetch = (fstate == RUN) & ~halt & ~redir_en & ~ifRST;
    assign hit_take  = run_fetch & ~skid_valid & ihit;

    ifid_skid u_skid (
        .CLK        (CLK),
        .RST        (RST),
        .load       (hit_take & ~ifW),
        .drain      (run_fetch & skid_valid & ifW),
        .clear      (halt | ((fstate == RUN) & (redir_en | ifRST))),
        .instr_in   (imemload),
        .npc_in     (pc_next4),
        .skid_instr (skid_instr),
        .skid_npc   (skid_npc),
        .skid_valid (skid_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            fstate     <= RUN;
            pc         <= PC_INIT;
            pend_pc    <= '0;
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            if (halt) begin
                fstate <= HALTED;
            end else if (fstate == DRAIN) begin
                // Stale word arrives: discard it and jump to the newest target.
                if (redir_en) pend_pc <= redir_pc;
                if (ihit) begin
                    pc     <= redir_en ? redir_pc : pend_pc;
                    fstate <= RUN;
                end
            end else if (fstate == RUN) begin
                if (redir_en) begin
                    // Keep the address stable for an outstanding miss.
                    if (miss) begin
                        pend_pc <= redir_pc;
                        fstate  <= DRAIN;
                    end else begin
                        pc <= redir_pc;
                    end
                end else if (hit_take) begin
                    pc <= pc_next4;
                end
            end
            if (!run_fetch) begin
                if (ifW || ifRST) begin
                    ifid_instr <= '0;
                    ifid_npc   <= '0;
                    ifid_valid <= 1'b0;
                end
            end else if (ifW) begin
                ifid_instr <= skid_valid ? skid_instr : ihit ? imemload : '0;
                ifid_npc   <= skid_valid ? skid_npc : ihit ? pc_next4 : '0;
                ifid_valid <= skid_valid | ihit;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan steps plus random traffic against a behavioural model.
module tb_fetch_stage;
    logic        CLK = 1'b0, RST, ihit, imemREN, ifW, ifRST, redir_en, halt, ifid_valid;
    logic [31:0] imemload, imemaddr, redir_pc, ifid_instr, ifid_npc;
    int errors = 0, checks = 0;

    typedef struct {logic [31:0] i; logic [31:0] n;} ent_t;
    ent_t        sq[$];
    logic [31:0] m_pc, m_pend, m_instr, m_npc;
    logic        m_valid, m_halted, m_drain;

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
        .imemaddr(imemaddr), .ifW(ifW), .ifRST(ifRST), .redir_en(redir_en),
        .redir_pc(redir_pc), .halt(halt), .ifid_instr(ifid_instr),
        .ifid_npc(ifid_npc), .ifid_valid(ifid_valid)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imemload = mem(imemaddr);

    function automatic logic m_ren();
        return m_halted ? 1'b0 : m_drain ? 1'b1 : (sq.size() == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 0; m_pend = 0; m_halted = 0; m_drain = 0; sq.delete();
        m_instr = 0; m_npc = 0; m_valid = 0;
    endtask

    task automatic m_zero();
        m_instr = 0; m_npc = 0; m_valid = 0;
    endtask

    task automatic m_update(input logic r, h, w, f, rd, input logic [31:0] rp, input logic hl);
        logic ren;
        ent_t e;
        ren = m_ren();
        if (r) begin
            m_reset();
        end else if (hl) begin
            m_halted = 1; m_drain = 0; sq.delete();
            if (w || f) m_zero();
        end else if (m_halted) begin
            if (w || f) m_zero();
        end else if (m_drain) begin
            if (rd) m_pend = rp;
            if (h) begin m_pc = m_pend; m_drain = 0; end
            if (w || f) m_zero();
        end else if (rd) begin
            if (ren && !h) begin m_pend = rp; m_drain = 1; end
            else begin m_pc = rp; sq.delete(); end
            if (w || f) m_zero();
        end else if (f) begin
            sq.delete(); m_zero();
        end else if (sq.size() != 0) begin
            if (w) begin e = sq.pop_front(); m_instr = e.i; m_npc = e.n; m_valid = 1; end
        end else if (h) begin
            e.i = mem(m_pc); e.n = m_pc + 4; m_pc = m_pc + 4;
            if (w) begin m_instr = e.i; m_npc = e.n; m_valid = 1; end
            else sq.push_back(e);
        end else if (w) begin
            m_zero();
        end
    endtask

    task automatic step(input logic r, h, w, f, rd, input logic [31:0] rp, input logic hl);
        RST = r; ihit = h; ifW = w; ifRST = f; redir_en = rd; redir_pc = rp; halt = hl;
        #1;
        chk("imemREN", {31'b0, imemREN}, {31'b0, m_ren()});
        chk("imemaddr", imemaddr, m_pc);
        m_update(r, h, w, f, rd, rp, hl);
        @(posedge CLK);
        #1;
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_npc", ifid_npc, m_npc);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    endtask

    initial begin
        logic [31:0] rp;
        RST = 1; ihit = 0; ifW = 0; ifRST = 0; redir_en = 0; redir_pc = 0; halt = 0;
        repeat (2) @(posedge CLK);
        #1;
        m_reset();
        RST = 0;
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_addr", imemaddr, 32'h0);
        chk("rst_ren", {31'b0, imemREN}, 32'd1);
        // straight line
        step(0, 1, 1, 0, 0, 0, 0);
        chk("line_npc0", ifid_npc, 32'h4);
        chk("line_addr1", imemaddr, 32'h4);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("line_npc1", ifid_npc, 32'h8);
        // stall with skid at pc=8
        step(0, 1, 0, 0, 0, 0, 0);
        chk("stall_hold", ifid_npc, 32'h8);
        chk("stall_ren0", {31'b0, imemREN}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("stall_ren2", {31'b0, imemREN}, 32'd0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("skid_npc", ifid_npc, 32'hC);
        chk("resume_addr", imemaddr, 32'hC);
        step(0, 1, 1, 0, 0, 0, 0);
        // redirect during miss at pc=10
        step(0, 0, 1, 0, 1, 32'h40, 0);
        chk("drain_addr0", imemaddr, 32'h10);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("drain_addr1", imemaddr, 32'h10);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("drain_drop", {31'b0, ifid_valid}, 32'd0);
        chk("drain_target", imemaddr, 32'h40);
        // flush at pc=20
        step(0, 1, 1, 0, 1, 32'h20, 0);
        chk("redir_hit_addr", imemaddr, 32'h20);
        step(0, 1, 1, 1, 0, 0, 0);
        chk("flush_npc", ifid_npc, 32'h0);
        chk("flush_refetch", imemaddr, 32'h20);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("refetch_npc", ifid_npc, 32'h24);
        // halt at pc=30, then reset
        step(0, 1, 1, 0, 1, 32'h30, 0);
        step(0, 1, 1, 0, 0, 0, 1);
        chk("halt_ren", {31'b0, imemREN}, 32'd0);
        step(0, 1, 1, 0, 1, 32'h50, 0);
        chk("halt_ignore_redir", imemaddr, 32'h30);
        step(1, 0, 1, 0, 0, 0, 0);
        chk("rst_after_halt_addr", imemaddr, 32'h0);
        chk("rst_after_halt_ren", {31'b0, imemREN}, 32'd1);
        // wrap and priority
        step(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("wrap_npc", ifid_npc, 32'h0);
        chk("wrap_addr", imemaddr, 32'h0);
        step(0, 0, 1, 0, 1, 32'h80, 1);
        chk("halt_over_redir", {31'b0, imemREN}, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int k = 0; k < 600; k++) begin
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 12, rp, $urandom_range(0, 99) < 2);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC, issues read requests to the instruction cache, and writes the IF/ID pipeline register. The hazard unit sits directly downstream and gates this block's IF/ID latch with `ifW` and its flush with `ifRST`. Branch/jump redirects, including redirects that arrive while an I-cache miss is outstanding, are absorbed here. A one-entry skid buffer keeps a fetched word from being lost while IF/ID is stalled.

## Interface
- `PC_INIT`, default 32'h0000_0000: PC value loaded on reset.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ihit`  in  1  I-cache hit; `imemload` is valid in the same cycle.
- `imemload`  in  32  instruction word returned for `imemaddr`.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  request address; equals `pc`.
- `ifW`  in  1  IF/ID write enable from the hazard unit.
- `ifRST`  in  1  IF/ID flush from the hazard unit.
- `redir_en`  in  1  taken branch, J, JAL or JR resolved this cycle.
- `redir_pc`  in  32  redirect target.
- `halt`  in  1  HALT reached; stop fetching.
- `ifid_instr`  out  32  registered instruction.
- `ifid_npc`  out  32  registered PC+4 of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction (0 means bubble).

## Operation
- State register `fstate`: RUN, DRAIN, HALTED. Internal registers:
  - `pc`
  - `pend_pc`
  - skid entry `{skid_instr, skid_npc, skid_valid}`
- Per-cycle priority: `RST` > `halt` > `redir_en` > `ifRST` > normal fetch.
- **RUN**
  - `imemREN = !skid_valid`; `imemaddr = pc`.
  - **Redirect, no hit pending:** when `redir_en` and not (`imemREN && !ihit`):
    - `pc <= redir_pc`; `skid_valid <= 0`.
    - Any word hitting this cycle is dropped.
  - **Redirect during a miss:** when `redir_en` with `imemREN && !ihit`:
    - `pend_pc <= redir_pc`; go to DRAIN.
    - `pc` holds, so the address stays stable for the cache.
  - **Hit, `ifW=1`, `ifRST=0`:**
    - IF/ID <= `{imemload, pc+4, 1}`.
    - `pc <= pc+4`.
  - **Hit, `ifW=0`:**
    - skid <= `{imemload, pc+4, 1}`.
    - `pc <= pc+4`.
    - IF/ID holds.
  - **Hit with `ifRST=1`:**
    - Word dropped; `pc` not advanced, so the word is refetched.
    - IF/ID cleared.
  - **`skid_valid`, `ifW=1`, `ifRST=0`:**
    - IF/ID <= skid; `skid_valid <= 0`.
  - **`skid_valid` and `ifRST=1`:**
    - `skid_valid <= 0`; IF/ID cleared.
  - **No hit, no skid, `ifW=1`:** IF/ID <= bubble `{0, 0, 0}`.
  - **`ifRST=1`:** forces IF/ID to all-zero regardless of `ifW`.
  - **`ifW=0` and `ifRST=0`:** IF/ID holds.
- **DRAIN**
  - `imemREN = 1`; `imemaddr = pc` (old address, held).
  - On `ihit`: the word is discarded, `pc <= pend_pc`, next state RUN.
  - A further `redir_en` overwrites `pend_pc`.
  - IF/ID gets a bubble when `ifW=1`; cleared when `ifRST=1`.
- **HALTED**
  - Entered from any state on `halt`; an outstanding request is abandoned.
  - `imemREN = 0`.
  - IF/ID gets a bubble when `ifW=1`.
  - Exit only via `RST`.
- **Arithmetic:** `pc+4` is a 32-bit add with wrap; 32'hFFFF_FFFC + 4 = 32'h0000_0000. No alignment check; `redir_pc` is used as given.

## Timing
- **Reset:**
  - `pc = PC_INIT`, `fstate = RUN`, `pend_pc = 0`, `skid_valid = 0`.
  - `ifid_instr = 0`, `ifid_npc = 0`, `ifid_valid = 0`.
  - In the first cycle after reset, `imemREN = 1` and `imemaddr = PC_INIT`.
- **Latency:** an `ihit` in cycle N appears on IF/ID in cycle N+1 if `ifW=1` in N.
- **Throughput:** one instruction per cycle on back-to-back hits.
- **Skid drain:** one cycle after `ifW` rises. No fetch is issued while the skid is full, so a word is never lost and never duplicated.
- **Redirect while idle or on a hit:** the new address is presented on the next cycle.
- **Redirect during a miss:** the new address is presented the cycle after the stale hit.
- `imemaddr` never changes while `imemREN && !ihit` in RUN or DRAIN.
- **`RST` mid-miss:** the request is dropped; the next cycle fetches `PC_INIT`.
- All outputs are registered except `imemREN` and `imemaddr`, which are combinational from state.

## Structure
- In `cpu_types_pkg`:
  - `word_t` (32-bit)
  - `fetch_state_t` enum {RUN, DRAIN, HALTED}
  - `WBYTES` = 4
- One sub-module: `ifid_skid`, the one-entry buffer with load, drain and clear controls.
- PC, redirect logic and the FSM stay in `fetch_stage`.

## Test plan
- **Straight line:** reset with `PC_INIT`=0, `ihit`=1 every cycle, `ifW`=1.
  - `imemaddr` steps 0, 4, 8, C.
  - `ifid_npc` steps 4, 8, C, 10, one cycle behind.
  - `ifid_valid`=1 from cycle 2.
- **Stall with skid:** `ihit`=1 at pc=8 while `ifW`=0 for 3 cycles.
  - IF/ID holds its prior value.
  - `imemREN`=0 for the remaining 2 cycles.
  - On `ifW`=1, `ifid_npc`=C; fetch resumes at C.
- **Redirect during miss:** `ihit`=0 at pc=10, `redir_en` with `redir_pc`=40, `ihit`=1 two cycles later.
  - `imemaddr` stays 10 until the hit.
  - That word is dropped.
  - Next `imemaddr`=40.
- **Flush:** `ifRST`=1 with `ihit`=1 at pc=20.
  - IF/ID becomes all-zero.
  - `pc` stays 20 and the word is refetched.
- **Halt and reset:** `halt` at pc=30.
  - `imemREN`=0 from the next cycle onward, and it ignores `redir_en`.
  - `RST` gives `imemaddr` = `PC_INIT` and `ifid_valid`=0.
- **Wrap and priority:** pc=FFFF_FFFC with `ihit` gives `ifid_npc`=0.
  - `redir_en` and `halt` together gives HALTED.
